// File: rtl/mips_pkg.sv
// mips_pkg: shared types for the MIPS pipeline stages.
//   - ANCHO / ANCHO_REG: data word width and register-index width
//   - estado_t: MEM-stage access FSM states
//   - exmem_t / memwb_t: contents of the EX/MEM and MEM/WB latches
package mips_pkg;

   localparam int ANCHO     = 32;
   localparam int ANCHO_REG = 5;

   typedef enum logic {
      LIBRE  = 1'b0,
      ESPERA = 1'b1
   } estado_t;

   typedef struct packed {
      logic                 valid;
      logic                 reg_escribir;
      logic                 mem_a_reg;
      logic                 mem_escribir;
      logic                 mem_leer;
      logic                 branch;
      logic [ANCHO-1:0]     alu;
      logic [ANCHO-1:0]     dato;
      logic [ANCHO-1:0]     target;
      logic [ANCHO_REG-1:0] rd;
   } exmem_t;

   typedef struct packed {
      logic                 valid;
      logic                 reg_escribir;
      logic                 mem_a_reg;
      logic                 error_alineacion;
      logic [ANCHO-1:0]     dato_leido;
      logic [ANCHO-1:0]     alu;
      logic [ANCHO_REG-1:0] rd;
   } memwb_t;

endpackage

// File: rtl/memoria_datos.sv
// memoria_datos: PROFUNDIDAD x 32-bit data memory.
//   clk            clock (rising edge)
//   escribir       synchronous write enable
//   indice         word index for both read and write
//   dato_escritura write data
//   dato_lectura   combinational read of the addressed word
// Contents are deliberately not reset.
module memoria_datos
   import mips_pkg::*;
#(
   parameter int PROFUNDIDAD = 256,
   parameter int ANCHO_IDX   = 8
) (
   input  logic                 clk,
   input  logic                 escribir,
   input  logic [ANCHO_IDX-1:0] indice,
   input  logic [ANCHO-1:0]     dato_escritura,
   output logic [ANCHO-1:0]     dato_lectura
);

   logic [ANCHO-1:0] mem [PROFUNDIDAD];

   always_ff @(posedge clk) begin
      if (escribir) mem[indice] <= dato_escritura;
   end

   assign dato_lectura = mem[indice];

endmodule

// File: rtl/etapa_mem.sv
// etapa_mem: MEM stage of the 5-stage MIPS pipeline.
//   Holds the EX/MEM latch, runs word loads/stores against memoria_datos with
//   LATENCIA cycles of occupancy, stalls upstream (detener) while an access is
//   in flight, and produces the MEM/WB latch plus the branch redirect.
//   Inputs  : clk, rst_n (sync, active low), *_EX fields from the EXE stage.
//   Outputs : detener to IF/ID/EX, *_WB MEM/WB latch, pc_src_MEM and
//             branch_target_MEM to IF.
module etapa_mem
   import mips_pkg::*;
#(
   parameter int PROFUNDIDAD = 256,
   parameter int LATENCIA    = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 valid_EX,
   input  logic [ANCHO-1:0]     resultado_alu_EX,
   input  logic [ANCHO-1:0]     dr2_forward_EX,
   input  logic [ANCHO_REG-1:0] registro_destino_EX,
   input  logic                 branch_habilitado_EX,
   input  logic [ANCHO-1:0]     branch_target_EX,
   input  logic                 reg_escribir_EX,
   input  logic                 mem_a_reg_EX,
   input  logic                 mem_escribir_EX,
   input  logic                 mem_leer_EX,
   output logic                 detener,
   output logic                 valid_WB,
   output logic                 reg_escribir_WB,
   output logic                 mem_a_reg_WB,
   output logic [ANCHO-1:0]     dato_leido_WB,
   output logic [ANCHO-1:0]     resultado_alu_WB,
   output logic [ANCHO_REG-1:0] registro_destino_WB,
   output logic                 error_alineacion_WB,
   output logic                 pc_src_MEM,
   output logic [ANCHO-1:0]     branch_target_MEM
);

   localparam int         ANCHO_IDX  = $clog2(PROFUNDIDAD);
   localparam logic [2:0] CUENTA_FIN = 3'(LATENCIA - 1);

   estado_t    estado, estado_sig;
   logic [2:0] cuenta, cuenta_sig;
   exmem_t     ex;
   memwb_t     wb;
   logic       completa, mem_op, desalineado, escribir;
   logic [ANCHO-1:0] dato_mem;

   assign mem_op      = ex.valid & (ex.mem_leer | ex.mem_escribir);
   assign desalineado = |ex.alu[1:0];
   // Reset wins over a store completing on the same edge.
   assign escribir    = completa & ex.valid & ex.mem_escribir & ~desalineado & rst_n;

   always_comb begin
      estado_sig = estado;
      cuenta_sig = cuenta;
      detener    = 1'b0;
      completa   = 1'b0;
      case (estado)
         LIBRE: begin
            if (mem_op && LATENCIA > 1) begin
               estado_sig = ESPERA;
               cuenta_sig = 3'd1;
               detener    = 1'b1;
            end else begin
               completa = 1'b1;
            end
         end
         ESPERA: begin
            if (cuenta == CUENTA_FIN) begin
               estado_sig = LIBRE;
               cuenta_sig = 3'd0;
               completa   = 1'b1;
            end else begin
               cuenta_sig = 3'(cuenta + 3'd1);
               detener    = 1'b1;
            end
         end
         default: begin
            estado_sig = LIBRE;
            cuenta_sig = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado <= LIBRE;
         cuenta <= 3'd0;
         ex     <= '0;
         wb     <= '0;
      end else begin
         estado <= estado_sig;
         cuenta <= cuenta_sig;
         if (!detener) begin
            // A bubble clears the whole latch so no stale control leaks out.
            if (valid_EX)
               ex <= '{valid: 1'b1, reg_escribir: reg_escribir_EX, mem_a_reg: mem_a_reg_EX,
                       mem_escribir: mem_escribir_EX, mem_leer: mem_leer_EX,
                       branch: branch_habilitado_EX, alu: resultado_alu_EX,
                       dato: dr2_forward_EX, target: branch_target_EX,
                       rd: registro_destino_EX};
            else
               ex <= '0;
         end
         // MEM/WB only carries an instruction on its completion edge; stall
         // cycles show up in WB as bubbles.
         if (completa) begin
            wb.valid            <= ex.valid;
            wb.reg_escribir     <= ex.reg_escribir;
            wb.mem_a_reg        <= ex.mem_a_reg;
            wb.error_alineacion <= mem_op & desalineado;
            wb.dato_leido       <= (ex.valid && ex.mem_leer && !desalineado) ? dato_mem : '0;
            wb.alu              <= ex.alu;
            wb.rd               <= ex.rd;
         end else begin
            wb <= '0;
         end
      end
   end

   memoria_datos #(.PROFUNDIDAD(PROFUNDIDAD), .ANCHO_IDX(ANCHO_IDX)) u_mem (
      .clk            (clk),
      .escribir       (escribir),
      .indice         (ex.alu[ANCHO_IDX+1:2]),
      .dato_escritura (ex.dato),
      .dato_lectura   (dato_mem)
   );

   assign valid_WB            = wb.valid;
   assign reg_escribir_WB     = wb.reg_escribir;
   assign mem_a_reg_WB        = wb.mem_a_reg;
   assign dato_leido_WB       = wb.dato_leido;
   assign resultado_alu_WB    = wb.alu;
   assign registro_destino_WB = wb.rd;
   assign error_alineacion_WB = wb.error_alineacion;
   assign pc_src_MEM          = ex.valid & ex.branch;
   assign branch_target_MEM   = ex.target;

endmodule

// File: tb/tb_etapa_mem.sv
// Bench for etapa_mem: two instances (LATENCIA 2 and 4, PROFUNDIDAD 256)
// compared every cycle against a timeline reference model, plus directed
// scenarios with constant expectations.
module tb_etapa_mem;

   typedef struct packed {
      logic v, rw, m2r, mw, mr, br;
      logic [31:0] alu, dat, tgt;
      logic [4:0] rd;
   } ins_t;

   typedef struct packed {
      logic v, rw, m2r, err;
      logic [31:0] dato, alu;
      logic [4:0] rd;
   } wbm_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ins_t in_x [2];
   logic        det [2], vwb [2], rwwb [2], m2rwb [2], errwb [2], pcs [2];
   logic [31:0] dwb [2], awb [2], tgt [2];
   logic [4:0]  rdwb [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      etapa_mem #(.PROFUNDIDAD(256), .LATENCIA(g == 0 ? 2 : 4)) dut (
         .clk                  (clk),
         .rst_n                (rst_n),
         .valid_EX             (in_x[g].v),
         .resultado_alu_EX     (in_x[g].alu),
         .dr2_forward_EX       (in_x[g].dat),
         .registro_destino_EX  (in_x[g].rd),
         .branch_habilitado_EX (in_x[g].br),
         .branch_target_EX     (in_x[g].tgt),
         .reg_escribir_EX      (in_x[g].rw),
         .mem_a_reg_EX         (in_x[g].m2r),
         .mem_escribir_EX      (in_x[g].mw),
         .mem_leer_EX          (in_x[g].mr),
         .detener              (det[g]),
         .valid_WB             (vwb[g]),
         .reg_escribir_WB      (rwwb[g]),
         .mem_a_reg_WB         (m2rwb[g]),
         .dato_leido_WB        (dwb[g]),
         .resultado_alu_WB     (awb[g]),
         .registro_destino_WB  (rdwb[g]),
         .error_alineacion_WB  (errwb[g]),
         .pc_src_MEM           (pcs[g]),
         .branch_target_MEM    (tgt[g])
      );
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: the instruction occupying MEM, how many cycles it has
   // been there, the resulting WB contents and a plain word array.
   ins_t        occ [2];
   int          age [2];
   wbm_t        wbm [2];
   logic [31:0] mm  [2][256];
   int          detc [2], pcc [2], errc [2];
   logic [31:0] last_ld [2];
   logic [4:0]  last_rd [2];

   function automatic int lat(input int d);
      return d == 0 ? 2 : 4;
   endfunction

   function automatic bit m_stall(input int d);
      return occ[d].v && (occ[d].mr || occ[d].mw) && age[d] < lat(d) - 1;
   endfunction

   task automatic model_edge(input int d);
      int  idx;
      bit  mis;
      if (!rst_n) begin
         occ[d] = '0; age[d] = 0; wbm[d] = '0;
      end else if (m_stall(d)) begin
         age[d]++; wbm[d] = '0;
      end else begin
         idx = int'(occ[d].alu >> 2) % 256;
         mis = occ[d].alu % 4 != 0;
         wbm[d].v    = occ[d].v;
         wbm[d].rw   = occ[d].rw;
         wbm[d].m2r  = occ[d].m2r;
         wbm[d].err  = (occ[d].mr || occ[d].mw) && mis;
         wbm[d].dato = (occ[d].mr && !mis) ? mm[d][idx] : 32'd0;
         wbm[d].alu  = occ[d].alu;
         wbm[d].rd   = occ[d].rd;
         if (occ[d].mw && !mis) mm[d][idx] = occ[d].dat;
         occ[d] = in_x[d].v ? in_x[d] : '0;
         age[d] = 0;
      end
   endtask

   task automatic check_dut(input int d);
      string p;
      p = $sformatf("d%0d_", d);
      chk({p, "detener"}, 32'(det[d]), 32'(m_stall(d)));
      chk({p, "valid_wb"}, 32'(vwb[d]), 32'(wbm[d].v));
      chk({p, "rw_wb"}, 32'(rwwb[d]), 32'(wbm[d].rw));
      chk({p, "m2r_wb"}, 32'(m2rwb[d]), 32'(wbm[d].m2r));
      chk({p, "err_wb"}, 32'(errwb[d]), 32'(wbm[d].err));
      chk({p, "dato_wb"}, dwb[d], wbm[d].dato);
      chk({p, "alu_wb"}, awb[d], wbm[d].alu);
      chk({p, "rd_wb"}, 32'(rdwb[d]), 32'(wbm[d].rd));
      chk({p, "pc_src"}, 32'(pcs[d]), 32'(occ[d].v & occ[d].br));
      chk({p, "target"}, tgt[d], occ[d].tgt);
      if (det[d]) detc[d]++;
      if (pcs[d]) pcc[d]++;
      if (errwb[d]) errc[d]++;
      if (vwb[d] && m2rwb[d]) begin last_ld[d] = dwb[d]; last_rd[d] = rdwb[d]; end
   endtask

   task automatic step();
      @(posedge clk);
      for (int d = 0; d < 2; d++) model_edge(d);
      #1;
      for (int d = 0; d < 2; d++) check_dut(d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Present an instruction and hold it until the stage accepts it.
   task automatic issue(input int d, input ins_t i);
      bit taken = 0;
      in_x[d] = i;
      for (int c = 0; c < 16 && !taken; c++) begin
         taken = !m_stall(d);
         step();
      end
      if (!taken) chk("issue_timeout", 32'd1, 32'd0);
      in_x[d] = '0;
   endtask

   function automatic ins_t ld(input logic [31:0] a, input logic [4:0] rd);
      ins_t i = '0;
      i.v = 1; i.mr = 1; i.m2r = 1; i.rw = 1; i.alu = a; i.rd = rd;
      return i;
   endfunction

   function automatic ins_t st(input logic [31:0] a, input logic [31:0] dat);
      ins_t i = '0;
      i.v = 1; i.mw = 1; i.alu = a; i.dat = dat;
      return i;
   endfunction

   function automatic ins_t alu_i(input logic [31:0] r, input logic [4:0] rd);
      ins_t i = '0;
      i.v = 1; i.rw = 1; i.alu = r; i.rd = rd;
      return i;
   endfunction

   function automatic ins_t brn(input logic [31:0] t);
      ins_t i = '0;
      i.v = 1; i.br = 1; i.tgt = t;
      return i;
   endfunction

   function automatic ins_t rnd_ins();
      ins_t i;
      logic [31:0] a;
      a = {$urandom_range(0, 1) ? 22'($urandom) : 22'd0, 4'($urandom_range(0, 15)), 2'b00, 2'b00};
      a = {a[31:10], a[9:6] * 0 + 4'd0, a[5:2] ^ a[9:6], ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00};
      i = {6'($urandom), 32'($urandom), 32'($urandom), 32'($urandom), 5'($urandom)};
      case ($urandom_range(0, 3))
         0: begin i.mr = 1; i.mw = 0; i.m2r = 1; i.rw = 1; i.br = 0; i.alu = a; end
         1: begin i.mr = 0; i.mw = 1; i.m2r = 0; i.rw = 0; i.br = 0; i.alu = a; end
         2: begin i.mr = 0; i.mw = 0; i.m2r = 0; i.rw = 1; i.br = 0; end
         default: begin i.mr = 0; i.mw = 0; i.m2r = 0; i.rw = 0; end
      endcase
      i.v = $urandom_range(0, 9) != 0;
      return i;
   endfunction

   initial begin
      for (int d = 0; d < 2; d++) begin
         in_x[d] = '0; occ[d] = '0; age[d] = 0; wbm[d] = '0;
      end
      rst_n = 0;
      idle(2);
      rst_n = 1;
      // Give every word the random traffic touches a defined value.
      for (int w = 0; w < 16; w++)
         for (int d = 0; d < 2; d++) issue(d, st(32'(w * 4), $urandom));
      idle(5);

      // Reset with a valid store presented: nothing reaches WB or memory.
      rst_n = 0;
      in_x[0] = st(32'h10, 32'hCAFEF00D);
      idle(2);
      chk("rst_detener", 32'(det[0]), 32'd0);
      chk("rst_valid_wb", 32'(vwb[0]), 32'd0);
      chk("rst_target", tgt[0], 32'd0);
      in_x[0] = '0;
      rst_n = 1;
      step();
      detc[0] = 0;
      issue(0, ld(32'h10, 5'd3));
      idle(4);
      chk("rst_mem_kept", last_ld[0], mm[0][4]);

      // Store then load, LATENCIA 2.
      detc[0] = 0;
      issue(0, st(32'h10, 32'hDEADBEEF));
      issue(0, ld(32'h10, 5'd5));
      idle(4);
      chk("sl_detener_cycles", 32'(detc[0]), 32'd2);
      chk("sl_load_data", last_ld[0], 32'hDEADBEEF);
      chk("sl_load_rd", 32'(last_rd[0]), 32'd5);

      // LATENCIA 4: load followed by an ALU op held upstream.
      detc[1] = 0;
      issue(1, ld(32'h8, 5'd7));
      issue(1, alu_i(32'h1234_5678, 5'd9));
      idle(6);
      chk("l4_detener_cycles", 32'(detc[1]), 32'd3);

      // Misaligned store and load.
      errc[0] = 0;
      issue(0, st(32'h13, 32'h0BAD0BAD));
      issue(0, ld(32'h12, 5'd6));
      idle(4);
      chk("mis_err_count", 32'(errc[0]), 32'd2);
      chk("mis_load_zero", last_ld[0], 32'd0);
      issue(0, ld(32'h10, 5'd6));
      idle(4);
      chk("mis_word_kept", last_ld[0], 32'hDEADBEEF);

      // Address wrap-around.
      issue(0, st(32'h400, 32'h1234));
      issue(0, ld(32'h000, 5'd8));
      idle(4);
      chk("wrap_load", last_ld[0], 32'h1234);

      // Branch redirect visible for exactly one cycle.
      pcc[0] = 0;
      issue(0, brn(32'h40));
      chk("br_target", tgt[0], 32'h40);
      idle(3);
      chk("br_pc_src_cycles", 32'(pcc[0]), 32'd1);

      // Reset lands on the store's completion edge.
      issue(0, st(32'h20, 32'h5555AAAA));
      step();
      rst_n = 0;
      step();
      rst_n = 1;
      issue(0, ld(32'h20, 5'd4));
      idle(4);
      chk("rst_store_dropped", 32'(last_ld[0] != 32'h5555AAAA), 32'd1);

      // Randomized traffic on both instances.
      for (int d = 0; d < 2; d++) begin
         for (int n = 0; n < 250; n++) begin
            issue(d, rnd_ins());
            if ($urandom_range(0, 7) == 0) idle(1);
         end
         idle(6);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/etapa_mem.md
# etapa_mem

MEM stage of the 5-stage MIPS pipeline: consumes the EXE stage's ALU result, store data, destination register, branch decision and forwarded MEM/WB controls. It holds the EX/MEM latch, performs word loads and stores against an internal data memory with programmable multi-cycle latency, and stalls upstream while an access is in flight. It also produces the registered MEM/WB latch and the branch redirect (PCSrc) to IF.

## Interface
- PROFUNDIDAD, 256: data memory depth in 32-bit words (power of two, 16..4096).
- LATENCIA, 2: cycles a load/store occupies MEM (1..7).

- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- valid_EX  in  1  EXE slot holds a real instruction (0 = bubble).
- resultado_alu_EX  in  32  address for loads/stores, or result.
- dr2_forward_EX  in  32  store data.
- registro_destino_EX  in  5  destination register.
- branch_habilitado_EX  in  1  branch taken.
- branch_target_EX  in  32  branch target.
- reg_escribir_EX, mem_a_reg_EX, mem_escribir_EX, mem_leer_EX  in  1 each  forwarded controls.
- detener  out  1  stall to IF/ID/EX (combinational from state).
- valid_WB  out  1  MEM/WB holds a real instruction.
- reg_escribir_WB, mem_a_reg_WB  out  1 each  controls to WB (forced 0 when valid_WB=0).
- dato_leido_WB  out  32  load data.
- resultado_alu_WB  out  32  ALU result.
- registro_destino_WB  out  5  destination register.
- error_alineacion_WB  out  1  misaligned access flag for the instruction in WB.
- pc_src_MEM  out  1  take branch.
- branch_target_MEM  out  32  redirect address.

## Operation
- EX/MEM latch loads all EX inputs on every edge where detener=0. valid_EX=0 loads a bubble: all controls and branch_habilitado cleared.
- FSM states LIBRE and ESPERA, with a 3-bit counter cuenta.
- LIBRE:
  - If the latch holds a valid memory op (mem_leer or mem_escribir) and LATENCIA>1: go to ESPERA, cuenta=1, detener=1.
  - Otherwise the instruction completes this cycle.
- ESPERA:
  - cuenta increments each cycle; detener=1 while cuenta<LATENCIA-1.
  - When cuenta==LATENCIA-1: detener=0, the access completes, return to LIBRE.
- Completion edge:
  - MEM/WB loads valid, controls, result and register.
  - A store writes memory exactly once.
  - A load registers memory[índice] into dato_leido_WB.
  - Non-loads set dato_leido_WB=0.
- Word index = resultado_alu[log2(PROFUNDIDAD)+1:2]. Upper address bits are ignored (wrap-around).
- Misaligned access (bits[1:0]≠0):
  - Store suppressed.
  - Load returns 0.
  - error_alineacion_WB=1 for that instruction only.
- pc_src_MEM = valid & branch_habilitado of the EX/MEM latch. branch_target_MEM comes straight from the latch.
- Memory contents are not reset.

## Timing
- Reset (rst_n=0 at an edge): FSM→LIBRE, cuenta=0, both latches cleared to bubble.
  - All outputs 0, including detener, pc_src_MEM, branch_target_MEM and the WB data fields.
  - Reset has priority over a completing store: the store does not commit. Reset mid-access abandons the access.
- Non-memory instruction latched at edge k: MEM/WB valid after edge k+1.
- Memory op latched at edge k: MEM/WB valid after edge k+LATENCIA. detener is high for cycles k..k+LATENCIA-2.
- LATENCIA=1: detener never asserts; throughput is 1 instruction/cycle.
- Back-to-back store then load to the same word: the store commits on its completion edge, so the load returns the new data.
- Load and store never overlap: only one instruction occupies MEM.
- While detener=1, EX inputs are ignored. Upstream must hold them; no input is lost.

## Structure
- Shared package/include mips_pkg: FSM state encodings LIBRE/ESPERA, the 32-bit word width constant, and the register-index width 5.
- One sub-module, memoria_datos:
  - PROFUNDIDAD×32 array.
  - Synchronous write enable.
  - Combinational read on index.
  - etapa_mem registers the read into MEM/WB.
- Top level contains the EX/MEM latch, FSM/counter, alignment check and MEM/WB latch.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with valid_EX=1 and a store asserted → all outputs 0, detener=0, memory unchanged at the store address.
- Store then load, LATENCIA=2:
  - Store 0xDEADBEEF at address 0x10, immediately followed by a load from 0x10 to register 5.
  - Required: detener high 1 cycle per op.
  - Load WB shows dato_leido=0xDEADBEEF, registro_destino=5, mem_a_reg=1.
- LATENCIA=4 stall: a single load → detener high exactly 3 cycles; WB valid 4 edges after latch; an ALU instruction held upstream reaches WB on the following edge.
- Misaligned:
  - Store to 0x13, then load from 0x12 → error_alineacion_WB=1 for each, load data 0.
  - Word 0x10 keeps its prior value.
- Wrap-around (PROFUNDIDAD=256): store 0x1234 at 0x400, then load from 0x000 → 0x1234.
- Branch and reset: branch_habilitado_EX=1 with target 0x40 → pc_src_MEM=1 and target 0x40 for one cycle. Reset asserted on a store's completion edge → store not committed.
